// File: rtl/g2b_pkg.sv
// Shared types and helpers for the gray-to-binary tracker: FSM state encoding,
// a width-generic gray decode and a popcount used for the Hamming-distance check.
package g2b_pkg;

  localparam int G2B_MAX_W = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  // b[i] = XOR of g[j] for j >= i, i.e. b[i] = b[i+1] ^ g[i] with b[w-1] = g[w-1]
  function automatic logic [G2B_MAX_W-1:0] gray2bin(input logic [G2B_MAX_W-1:0] g,
                                                    input int w);
    logic [G2B_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < w; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [G2B_MAX_W-1:0] v);
    int unsigned          cnt;
    logic [G2B_MAX_W-1:0] w_v;
    cnt = 0;
    w_v = v;
    for (int i = 0; i < G2B_MAX_W; i++) begin
      cnt = cnt + {31'b0, w_v[0]};
      w_v = w_v >> 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/g2b_sync.sv
// Multi-flop synchroniser for a gray-coded bus; only one bit changes per legal
// step, so per-bit synchronisation keeps the word coherent.
module g2b_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/g2b_tracker.sv
// Gray-to-binary receive tracker: synchronises an asynchronous gray bus, decodes
// it and flags +/-1 steps and illegal jumps. Optional error counter: G2B_TRACKER_ERR_CNT_EN.
//
// state | meaning
// FILL  | waiting SYNC_STAGES cycles for the synchroniser to fill after reset
// PRIME | load g_prev and bin_out from the first synchronised value, no pulses
// TRACK | compare each synchronised value with g_prev and report steps/jumps
module g2b_tracker
  import g2b_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  state_t              r_state,     w_state_n;
  logic [FILL_W-1:0]   r_fill,      w_fill_n;
  logic [WIDTH-1:0]    r_gprev,     w_gprev_n;
  logic [WIDTH-1:0]    r_bin,       w_bin_n;
  logic                r_dir,       w_dir_n;
  logic                r_bin_valid, w_bin_valid_n;
  logic                r_step_err,  w_step_err_n;

  logic [WIDTH-1:0]    w_gs;
  logic [WIDTH-1:0]    w_dec;
  int unsigned         w_dist;

  g2b_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gray_in),
    .o_q   (w_gs)
  );

  assign w_dec  = WIDTH'(gray2bin(G2B_MAX_W'(w_gs), WIDTH));
  assign w_dist = popcount(G2B_MAX_W'(w_gs ^ r_gprev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_fill      <= '0;
      r_gprev     <= '0;
      r_bin       <= '0;
      r_dir       <= 1'b0;
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_fill      <= w_fill_n;
      r_gprev     <= w_gprev_n;
      r_bin       <= w_bin_n;
      r_dir       <= w_dir_n;
      r_bin_valid <= w_bin_valid_n;
      r_step_err  <= w_step_err_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_fill_n      = r_fill;
    w_gprev_n     = r_gprev;
    w_bin_n       = r_bin;
    w_dir_n       = r_dir;
    w_bin_valid_n = 1'b0;
    w_step_err_n  = 1'b0;
    unique case (r_state)
      FILL: begin
        if (r_fill == FILL_W'(SYNC_STAGES - 1)) begin
          w_state_n = PRIME;
        end else begin
          w_fill_n = r_fill + 1'b1;
        end
      end
      PRIME: begin
        w_gprev_n = w_gs;
        w_bin_n   = w_dec;
        w_state_n = TRACK;
      end
      TRACK: begin
        if (w_dist != 0) begin
          w_gprev_n     = w_gs;
          w_bin_n       = w_dec;
          w_bin_valid_n = 1'b1;
          if (w_dist == 1) begin
            w_dir_n = (w_dec == WIDTH'(r_bin + 1'b1));
          end else begin
            // multi-bit jump: resynchronise to the new value, direction is meaningless
            w_step_err_n = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = FILL;
      end
    endcase
  end

  assign bin_out   = r_bin;
  assign dir       = r_dir;
  assign bin_valid = r_bin_valid;
  assign step_err  = r_step_err;

`ifdef G2B_TRACKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // counts on the same edge that raises step_err; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_step_err_n && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_cnt          = '0;
`endif

endmodule

// File: doc/g2b_tracker.md
Name: g2b_tracker

Overview:
- Receive-side counterpart of the team's binary-to-gray converter.
- Takes a gray-coded position or pointer bus that is asynchronous to clk, synchronises it, and decodes it to binary.
- Tracks successive values: flags each legal ±1 step with a direction bit and flags illegal multi-bit jumps.
- Sits at the consumer end of gray-coded pointer and position-sensor links.

Parameters:
- WIDTH, 4, width of the gray input and binary output.
- SYNC_STAGES, 2, synchroniser flop count (≥2).
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  WIDTH  gray code, asynchronous to clk
- err_clr  input  1  synchronous clear of err_cnt
- bin_out  output  WIDTH  decoded binary value (registered)
- bin_valid  output  1  one-cycle pulse when bin_out takes a new tracked value
- dir  output  1  1 = last step was +1 mod 2^WIDTH, 0 = −1
- step_err  output  1  one-cycle pulse on a jump of Hamming distance >1
- err_cnt  output  ERR_CNT_W  saturating count of step_err events

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. Asserting it, including mid-operation, immediately clears all outputs, synchroniser flops, g_prev and the fill counter to 0, and forces state FILL.
- Synchroniser: chain of SYNC_STAGES flops on gray_in; g_s is the last stage.
- Decode (combinational on g_s): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- State FILL: count SYNC_STAGES cycles after reset release, then go to PRIME. Outputs hold their reset values.
- State PRIME (1 cycle):
  - g_prev <= g_s; bin_out <= decode(g_s).
  - No bin_valid, no step_err.
  - Go to TRACK.
- State TRACK, every cycle, comparing g_s with g_prev:
  - Equal: no change; pulses low.
  - Distance 1:
    - bin_out <= decode(g_s); g_prev <= g_s; bin_valid=1.
    - dir <= 1 if decode(g_s) == bin_out+1 mod 2^WIDTH, else 0.
    - Wrap 15→0 is dir=1; 0→15 is dir=0.
  - Distance >1:
    - bin_out <= decode(g_s); g_prev <= g_s (resynchronise).
    - bin_valid=1, step_err=1; dir holds its previous value.
- Latency: a gray_in change captured at edge N appears on bin_out/bin_valid at edge N+SYNC_STAGES (registered output stage after the chain).
- err_cnt:
  - Increments on step_err and saturates at 2^ERR_CNT_W−1.
  - err_clr has priority: with step_err and err_clr in the same cycle, err_cnt becomes 0 and step_err still pulses.
- bin_valid and step_err are registered pulses, deasserted the following cycle unless a new event occurs.

Optional Feature:
- Macro G2B_TRACKER_ERR_CNT_EN.
- Defined: err_cnt and err_clr behave as above.
- Undefined:
  - The error counter is not built; err_cnt is tied to 0 and err_clr is ignored.
  - step_err detection and pulse remain active.
  - The port list is unchanged.

Decomposition:
- Package g2b_pkg:
  - state enum {FILL, PRIME, TRACK}.
  - function gray2bin(WIDTH-generic via parameterised loop).
  - function popcount for the Hamming-distance check.
- One natural sub-module: g2b_sync (parameterised SYNC_STAGES flop chain with async active-low reset), instantiated once.
- Decode stays in the package function, not a module.

Test Plan (WIDTH=4, SYNC_STAGES=2, ERR_CNT_W=2, macro defined):
- Prime: rst_n low→high with gray_in=0111 held → after fill+prime, bin_out=0101 (5), bin_valid never pulses, step_err=0.
- Up step: gray_in 0111→0101 → exactly 2 cycles later bin_out=0110, bin_valid 1 cycle, dir=1. Then 0101→0111 → bin_out=0101, dir=0.
- Wrap: gray 1000 (15)→0000 → bin_out=0000, dir=1. Then 0000→1000 → bin_out=1111, dir=0.
- Illegal jump: gray 0000→0101 → bin_out=0110, bin_valid=1, step_err=1, dir unchanged, err_cnt=1. Four further jumps → err_cnt saturates at 3. err_clr together with a jump → err_cnt=0 and step_err=1.
- Reset mid-run: rst_n low during TRACK, asynchronous to clk → all outputs 0 before the next edge. After release, FILL/PRIME repeat with no spurious bin_valid or step_err.
